// File: rtl/cond_flags_unit.sv
// cond_flags_unit
//   Holds the architectural NZCV flags for the single-cycle core. It gates the
//   decoder's register-write, memory-write and PC-source requests with the
//   condition checker's verdict, saves and restores the flags around exception
//   entry and return, and keeps a saturating count of suppressed instructions.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   alu_flags    : {N,Z,C,V} produced by the ALU this cycle
//   flag_w       : [1] update N,Z  [0] update C,V
//   cond_ex      : condition-pass verdict (combinational, from the checker)
//   reg_w_in / mem_w_in / pc_s_in : raw decoder write/branch requests
//   stall        : freeze all state and force the gated outputs low
//   exc_req      : exception entry request (level, held until taken)
//   exc_ret      : exception return request (level, held until taken)
//   flags        : architectural {N,Z,C,V}
//   reg_w / mem_w / pc_s : gated requests
//   in_exc       : high while in the exception state
//   squash_cnt   : saturating count of suppressed instructions
module cond_flags_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             cond_ex,
    input  logic             reg_w_in,
    input  logic             mem_w_in,
    input  logic             pc_s_in,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             exc_ret,
    output logic [3:0]       flags,
    output logic             reg_w,
    output logic             mem_w,
    output logic             pc_s,
    output logic             in_exc,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_EXC    = 1'b1;

    logic [0:0]       state_q,  state_d;
    logic [3:0]       flags_q,  flags_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic take_exc;
    logic take_ret;
    logic pass;
    logic upd;
    logic squash;

    always_comb begin
        take_exc = exc_req & ~stall & (state_q == ST_NORMAL);
        take_ret = exc_ret & ~stall & (state_q == ST_EXC);

        // The instruction in the exception-entry cycle is killed outright;
        // a return does not kill its instruction, only its flag write.
        pass  = cond_ex & ~stall & ~take_exc;
        reg_w = reg_w_in & pass;
        mem_w = mem_w_in & pass;
        pc_s  = pc_s_in  & pass;

        upd    = pass & ~take_ret;
        squash = ~stall & ~cond_ex & ~take_exc &
                 (reg_w_in | mem_w_in | pc_s_in | (|flag_w));
    end

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;

        if (take_exc) begin
            // Save the pre-update flags; the live flags hold this cycle.
            shadow_d = flags_q;
            state_d  = ST_EXC;
        end else if (take_ret) begin
            flags_d = shadow_q;
            state_d = ST_NORMAL;
        end else if (upd) begin
            if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
        end

        if (squash && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            flags_q  <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign flags      = flags_q;
    assign in_exc     = (state_q == ST_EXC);
    assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// tb_cond_flags_unit
//   Directed bench for cond_flags_unit. Two instances share all inputs: one
//   with the default 16-bit squash counter and one with a 4-bit counter so
//   saturation can be reached quickly.
module tb_cond_flags_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  alu_flags;
    logic [1:0]  flag_w;
    logic        cond_ex;
    logic        reg_w_in, mem_w_in, pc_s_in;
    logic        stall, exc_req, exc_ret;

    logic [3:0]  flags, flags4;
    logic        reg_w, mem_w, pc_s, in_exc;
    logic        reg_w4, mem_w4, pc_s4, in_exc4;
    logic [15:0] squash_cnt;
    logic [3:0]  squash_cnt4;

    int errors = 0;
    int checks = 0;

    cond_flags_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .alu_flags(alu_flags), .flag_w(flag_w),
        .cond_ex(cond_ex), .reg_w_in(reg_w_in), .mem_w_in(mem_w_in),
        .pc_s_in(pc_s_in), .stall(stall), .exc_req(exc_req), .exc_ret(exc_ret),
        .flags(flags), .reg_w(reg_w), .mem_w(mem_w), .pc_s(pc_s),
        .in_exc(in_exc), .squash_cnt(squash_cnt)
    );

    cond_flags_unit #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .alu_flags(alu_flags), .flag_w(flag_w),
        .cond_ex(cond_ex), .reg_w_in(reg_w_in), .mem_w_in(mem_w_in),
        .pc_s_in(pc_s_in), .stall(stall), .exc_req(exc_req), .exc_ret(exc_ret),
        .flags(flags4), .reg_w(reg_w4), .mem_w(mem_w4), .pc_s(pc_s4),
        .in_exc(in_exc4), .squash_cnt(squash_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // cond_ex must be a clean 0/1 whenever the unit is not stalled.
    always @(negedge clk) begin
        if (!reset && !stall) begin
            checks++;
            if ($isunknown(cond_ex)) begin
                errors++;
                $display("FAIL cond_ex_known: got %b required 0 or 1", cond_ex);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] af, input logic [1:0] fw, input logic ce,
                         input logic rw, input logic mw, input logic ps,
                         input logic st, input logic er, input logic et);
        alu_flags = af; flag_w = fw; cond_ex = ce;
        reg_w_in = rw; mem_w_in = mw; pc_s_in = ps;
        stall = st; exc_req = er; exc_ret = et;
        #1;
    endtask

    task automatic idle();
        drive(4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        reset = 1'b0;
        idle();
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b required 0000", flags); end
        checks++; if (in_exc !== 1'b0) begin errors++; $display("FAIL reset_in_exc: got %b required 0", in_exc); end
        checks++; if (squash_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", squash_cnt); end
        checks++; if (squash_cnt4 !== 4'd0) begin errors++; $display("FAIL reset_cnt4: got %0d required 0", squash_cnt4); end
    endtask

    task automatic test_flag_update();
        drive(4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL flag_latency: got %b required 0000", flags); end
        tick();
        idle();
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flag_nzcv: got %b required 0100", flags); end
        drive(4'b1011, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (flags !== 4'b0111) begin errors++; $display("FAIL flag_cv_only: got %b required 0111", flags); end
        drive(4'b1000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (flags !== 4'b1011) begin errors++; $display("FAIL flag_nz_only: got %b required 1011", flags); end
    endtask

    task automatic test_gating();
        drive(4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({reg_w, mem_w, pc_s} !== 3'b101) begin errors++; $display("FAIL gate_pass: got %b required 101", {reg_w, mem_w, pc_s}); end
        drive(4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({reg_w, mem_w, pc_s} !== 3'b000) begin errors++; $display("FAIL gate_squash: got %b required 000", {reg_w, mem_w, pc_s}); end
        checks++; if (squash_cnt !== 16'd0) begin errors++; $display("FAIL squash_before: got %0d required 0", squash_cnt); end
        tick();
        idle();
        checks++; if (flags !== 4'b1011) begin errors++; $display("FAIL squash_flags_hold: got %b required 1011", flags); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL squash_after: got %0d required 1", squash_cnt); end
        // A failed condition with nothing to suppress is not counted.
        drive(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL squash_empty: got %0d required 1", squash_cnt); end
    endtask

    task automatic test_exception();
        drive(4'b1001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if ({reg_w, mem_w} !== 2'b00) begin errors++; $display("FAIL exc_entry_gate: got %b required 00", {reg_w, mem_w}); end
        tick();
        idle();
        checks++; if (in_exc !== 1'b1) begin errors++; $display("FAIL exc_entered: got %b required 1", in_exc); end
        checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL exc_flags_hold: got %b required 1001", flags); end
        // Handler writes flags; a second request while in EXC is ignored.
        drive(4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL handler_flags: got %b required 0100", flags); end
        checks++; if (in_exc !== 1'b1) begin errors++; $display("FAIL no_nesting: got %b required 1", in_exc); end
        drive(4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (reg_w !== 1'b1) begin errors++; $display("FAIL ret_gate: got %b required 1", reg_w); end
        tick();
        idle();
        checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL ret_restore: got %b required 1001", flags); end
        checks++; if (in_exc !== 1'b0) begin errors++; $display("FAIL ret_left: got %b required 0", in_exc); end
        // Return request in NORMAL is ignored; the flag write proceeds.
        drive(4'b0010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL ret_in_normal: got %b required 0010", flags); end
        checks++; if (in_exc !== 1'b0) begin errors++; $display("FAIL ret_in_normal_state: got %b required 0", in_exc); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL exc_cnt: got %0d required 1", squash_cnt); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            checks++; if ({reg_w, mem_w, pc_s} !== 3'b000) begin errors++; $display("FAIL stall_gate[%0d]: got %b required 000", i, {reg_w, mem_w, pc_s}); end
            tick();
            checks++; if ({in_exc, flags} !== 5'b0_0010) begin errors++; $display("FAIL stall_hold[%0d]: got %b required 00010", i, {in_exc, flags}); end
        end
        drive(4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if ({reg_w, mem_w, pc_s} !== 3'b000) begin errors++; $display("FAIL unstall_entry_gate: got %b required 000", {reg_w, mem_w, pc_s}); end
        tick();
        checks++; if ({in_exc, flags} !== 5'b1_0010) begin errors++; $display("FAIL unstall_entry: got %b required 10010", {in_exc, flags}); end
        drive(4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if ({in_exc, flags} !== 5'b1_0010) begin errors++; $display("FAIL stall_ret_hold: got %b required 10010", {in_exc, flags}); end
        drive(4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        checks++; if ({in_exc, flags} !== 5'b0_0010) begin errors++; $display("FAIL stall_ret_taken: got %b required 00010", {in_exc, flags}); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d required 1", squash_cnt); end
    endtask

    task automatic test_saturation();
        // Both counters start at 1 here.
        drive(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) tick();
        checks++; if (squash_cnt4 !== 4'd14) begin errors++; $display("FAIL sat_below: got %0d required 14", squash_cnt4); end
        tick();
        checks++; if (squash_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_reach: got %0d required 15", squash_cnt4); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (squash_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d required 15", squash_cnt4); end
        checks++; if (squash_cnt !== 16'd18) begin errors++; $display("FAIL cnt16_after17: got %0d required 18", squash_cnt); end
        // An instruction killed by exception entry is not counted.
        drive(4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (squash_cnt !== 16'd18) begin errors++; $display("FAIL exc_kill_uncounted: got %0d required 18", squash_cnt); end
        checks++; if (in_exc !== 1'b1) begin errors++; $display("FAIL sat_exc_entered: got %b required 1", in_exc); end
        drive(4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(4'hF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        idle();
        checks++; if ({in_exc, flags} !== 5'b0_0000) begin errors++; $display("FAIL reset_mid_exc: got %b required 00000", {in_exc, flags}); end
        checks++; if ({squash_cnt4, squash_cnt} !== 20'd0) begin errors++; $display("FAIL reset_mid_cnt: got %h required 00000", {squash_cnt4, squash_cnt}); end
        checks++; if ({in_exc4, flags4} !== 5'b0_0000) begin errors++; $display("FAIL reset_mid_exc4: got %b required 00000", {in_exc4, flags4}); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_flag_update();
        test_gating();
        test_exception();
        test_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
